// File: rtl/zero_count_seq.sv
// zero_count_seq: counts the zero bits of an NBYTES-wide word using a single
// byte-wide counter, one byte per clock, LSB byte first.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and out_count (plus ones_count) is stable for as long as out_valid is high.
// Once raised, out_valid stays high until the consumer takes it.
//
// Optional feature macro: ZC_ONES_OUT_EN adds the ones_count output
// (8*NBYTES - out_count), registered alongside out_count.
//
// dbg_state exposes the FSM state (0=IDLE, 1=COUNT, 2=DONE) for checkers.
module zero_count_seq #(
  parameter  int NBYTES = 4,
  localparam int CW     = $clog2(8*NBYTES+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_count,
`ifdef ZC_ONES_OUT_EN
  output logic [CW-1:0]       ones_count,
`endif
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [8*NBYTES-1:0]   shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         acc_q, acc_d;
  logic [CW-1:0]         out_count_q, out_count_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic [CW-1:0]         acc_sum;
`ifdef ZC_ONES_OUT_EN
  logic [CW-1:0]         ones_q, ones_d;
`endif

  // Zeros in one byte: 8 minus the number of set bits (0..8).
  function automatic logic [CW-1:0] byte_zeros(input logic [7:0] b);
    logic [CW-1:0] z;
    z = CW'(8);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) z = z - CW'(1);
    end
    return z;
  endfunction

  // Next-state and datapath logic; outputs are derived from the next state
  // so they come straight out of flops.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_count_d = out_count_q;
`ifdef ZC_ONES_OUT_EN
    ones_d      = ones_q;
`endif
    acc_sum     = acc_q + byte_zeros(shift_q[7:0]);

    case (state_q)
      IDLE: begin
        // in_ready is high here, so in_valid alone completes the transfer;
        // abort has no effect outside COUNT.
        if (in_valid) begin
          shift_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (abort) begin
          // The current byte is dropped and the result regs are untouched.
          state_d = IDLE;
        end else begin
          acc_d   = acc_sum;
          shift_d = shift_q >> 8;
          idx_d   = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            out_count_d = acc_sum;
`ifdef ZC_ONES_OUT_EN
            ones_d      = CW'(8*NBYTES) - acc_sum;
`endif
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef ZC_ONES_OUT_EN
      ones_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef ZC_ONES_OUT_EN
      ones_q      <= ones_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;
`ifdef ZC_ONES_OUT_EN
  assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_zero_count_seq.sv
// Directed bench for zero_count_seq (NBYTES=4, CW=6). Inputs change and
// outputs are sampled on the falling edge, away from the active edge.
module tb_zero_count_seq;

  localparam int NBYTES = 4;
  localparam int CW     = 6;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [8*NBYTES-1:0] in_data;
  logic                abort;
  logic                out_valid;
  logic                out_ready;
  logic [CW-1:0]       out_count;
  logic                busy;
  logic [1:0]          dbg_state;
`ifdef ZC_ONES_OUT_EN
  logic [CW-1:0]       ones_count;
`endif

  int n_checks;
  int n_errors;

  zero_count_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
`ifdef ZC_ONES_OUT_EN
    .ones_count(ones_count),
`endif
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for in_ready, then hold in_valid for exactly one edge.
  task automatic accept_word(input logic [31:0] data, input logic with_abort,
                             input string name);
    int waited;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s in_ready_timeout got=%b exp=1", name, in_ready);
    end
    in_valid = 1'b1;
    in_data  = data;
    abort    = with_abort;
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    in_data  = $urandom;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || dbg_state !== 2'd1) begin
      n_errors++;
      $display("FAIL %s accept busy=%b in_ready=%b state=%0d exp 1/0/1",
               name, busy, in_ready, dbg_state);
    end
  endtask

  // Accept a word and check latency, result and release with out_ready=1.
  task automatic run_word(input logic [31:0] data, input logic [CW-1:0] exp,
                          input logic with_abort, input string name);
    out_ready = 1'b1;
    accept_word(data, with_abort, name);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL %s early_valid got=%b exp=0", name, out_valid);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_count !== exp) begin
      n_errors++;
      $display("FAIL %s result valid=%b count=%0d exp valid=1 count=%0d",
               name, out_valid, out_count, exp);
    end
`ifdef ZC_ONES_OUT_EN
    n_checks++;
    if (ones_count !== CW'(32) - exp) begin
      n_errors++;
      $display("FAIL %s ones got=%0d exp=%0d", name, ones_count, CW'(32) - exp);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s release valid=%b in_ready=%b busy=%b exp 0/1/0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0 ||
        busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset in_ready=%b out_valid=%b count=%0d busy=%b state=%0d exp 1/0/0/0/0",
               in_ready, out_valid, out_count, busy, dbg_state);
    end
  endtask

  task automatic test_all_zero();
    run_word(32'h0000_0000, 6'd32, 1'b0, "all_zero");
  endtask

  task automatic test_all_ones();
    run_word(32'hFFFF_FFFF, 6'd0, 1'b0, "all_ones");
  endtask

  task automatic test_back_to_back();
    // bytes FF,00,0F,0F -> 0+8+4+4 ; then 01,00,00,80 -> 7+8+8+7
    run_word(32'h0F0F_00FF, 6'd16, 1'b0, "b2b_first");
    run_word(32'h8000_0001, 6'd30, 1'b0, "b2b_second");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    accept_word(32'h0F0F_00FF, 1'b0, "bp");
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      // A word offered in DONE must be ignored; abort too.
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      abort    = (i == 3);
      n_checks++;
      if (out_valid !== 1'b1 || out_count !== 6'd16 || in_ready !== 1'b0 ||
          dbg_state !== 2'd2) begin
        n_errors++;
        $display("FAIL bp_hold cyc=%0d valid=%b count=%0d in_ready=%b state=%0d exp 1/16/0/2",
                 i, out_valid, out_count, in_ready, dbg_state);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        out_count !== 6'd16) begin
      n_errors++;
      $display("FAIL bp_release valid=%b in_ready=%b busy=%b count=%0d exp 0/1/0/16",
               out_valid, in_ready, busy, out_count);
    end
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    accept_word(32'h0000_0000, 1'b0, "abort");
    @(negedge clk);          // first COUNT edge has passed
    abort = 1'b1;            // acts on the second COUNT edge
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_count !== 6'd16) begin
      n_errors++;
      $display("FAIL abort_idle busy=%b in_ready=%b valid=%b count=%0d exp 0/1/0/16",
               busy, in_ready, out_valid, out_count);
    end
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL abort_no_valid got=%b exp=0", out_valid);
      end
    end
    run_word(32'h0000_00FF, 6'd24, 1'b0, "after_abort");
    // abort together with the accept in IDLE: the accept wins
    run_word(32'h0000_00FF, 6'd24, 1'b1, "abort_in_idle");
  endtask

  task automatic test_reset_mid_count();
    out_ready = 1'b1;
    accept_word(32'h1234_5678, 1'b0, "rst_mid");
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0000;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0 ||
        busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL rst_mid in_ready=%b valid=%b count=%0d busy=%b state=%0d exp 1/0/0/0/0",
               in_ready, out_valid, out_count, busy, dbg_state);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_not_accepted busy=%b valid=%b exp 0/0", busy, out_valid);
      end
    end
    run_word(32'h00FF_00FF, 6'd16, 1'b0, "after_rst");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    @(negedge clk);
    test_reset();
    test_all_zero();
    test_all_ones();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
